// File: rtl/enable_seq_pkg.sv
// Shared types and helpers for the enable sequencer.
package enable_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RAMP = 2'b01,
        STOP = 2'b11
    } seq_state_t;

    // Width of the stage index; never narrower than one bit.
    function automatic int unsigned stage_idx_w(input int unsigned n_stages);
        return (n_stages <= 2) ? 1 : $clog2(n_stages);
    endfunction

endpackage

// File: rtl/seq_dwell_timer.sv
// Dwell down-counter: load a value, count to zero, hold at zero (never wraps).
module seq_dwell_timer #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);

    logic [DWELL_W-1:0] count_q;

    // Load has priority over counting; the counter parks at zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - DWELL_W'(1);
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/enable_sequencer.sv
// N-stage thermometer enable sequencer with per-stage dwell, abort and re-arm.
// Optional build macro SEQ_STROBE_PULSE_EN turns OUT_STROBE into a one-cycle
// pulse on STOP entry; by default OUT_STROBE is a level for all of STOP.
module enable_sequencer
    import enable_seq_pkg::*;
#(
    parameter int unsigned N_STAGES = 3,
    parameter int unsigned DWELL_W  = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                ABORT,
    input  logic                CLR,
    input  logic [DWELL_W-1:0]  DWELL,
    output logic [N_STAGES-1:0] EN,
    output logic                BUSY,
    output logic                OUT_STROBE
);

    localparam int unsigned K_W = stage_idx_w(N_STAGES);
    localparam logic [K_W-1:0] K_ONE  = K_W'(1);
    localparam logic [K_W-1:0] K_LAST = K_W'(N_STAGES - 1);

    seq_state_t         state_q;
    logic [K_W-1:0]     k_q;
    logic [DWELL_W-1:0] dwell_q;

    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_val;
    logic               tmr_expire;
    logic               strobe_c;

    seq_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Timer control: abort clears, accepted start loads DWELL, stage advance reloads dwell_q.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (ABORT) begin
            tmr_load = 1'b1;
        end else if (state_q == IDLE && START) begin
            tmr_load = 1'b1;
            tmr_val  = DWELL;
        end else if (state_q == RAMP && tmr_expire && k_q != K_LAST) begin
            tmr_load = 1'b1;
            tmr_val  = dwell_q;
        end
    end

    // Sequencer FSM: state, stage index and captured dwell.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            k_q     <= K_ONE;
            dwell_q <= '0;
        end else if (ABORT) begin
            state_q <= IDLE;
            k_q     <= K_ONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        state_q <= RAMP;
                        k_q     <= K_ONE;
                        dwell_q <= DWELL;
                    end
                end
                RAMP: begin
                    if (tmr_expire) begin
                        if (k_q == K_LAST) begin
                            state_q <= STOP;
                        end else begin
                            k_q <= k_q + K_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (CLR) begin
                        state_q <= IDLE;
                        k_q     <= K_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    k_q     <= K_ONE;
                end
            endcase
        end
    end

`ifdef SEQ_STROBE_PULSE_EN
    logic stop_seen_q;

    // Remembers that STOP was already occupied last cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stop_seen_q <= 1'b0;
        end else begin
            stop_seen_q <= (state_q == STOP);
        end
    end

    assign strobe_c = (state_q == STOP) && !stop_seen_q;
`else
    assign strobe_c = (state_q == STOP);
`endif

    // Moore output decode from registered state and stage index.
    always_comb begin
        EN         = '0;
        BUSY       = 1'b0;
        OUT_STROBE = 1'b0;
        case (state_q)
            IDLE: EN[0] = 1'b1;
            RAMP: begin
                BUSY = 1'b1;
                for (int unsigned i = 0; i < N_STAGES; i++) begin
                    EN[i] = (i <= 32'(k_q));
                end
            end
            STOP: OUT_STROBE = strobe_c;
            default: EN = '0;
        endcase
    end

endmodule

// File: tb/tb_enable_sequencer.sv
// Randomised + directed bench for enable_sequencer; two instances (N=3, N=5)
// share stimulus and are each checked against a timeline model.
module tb_enable_sequencer;

    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] dwell = '0;

    logic [2:0] en3;
    logic       busy3, strb3;
    logic [4:0] en5;
    logic       busy5, strb5;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode 0=idle 1=ramp 2=stop; t = cycles since START; age = cycles in STOP.
    int nst  [2] = '{3, 5};
    int mode [2];
    int t    [2];
    int d    [2];
    int age  [2];

    enable_sequencer #(.N_STAGES(3), .DWELL_W(DW)) u_dut3 (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .CLR(clr),
        .DWELL(dwell), .EN(en3), .BUSY(busy3), .OUT_STROBE(strb3)
    );

    enable_sequencer #(.N_STAGES(5), .DWELL_W(DW)) u_dut5 (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .CLR(clr),
        .DWELL(dwell), .EN(en5), .BUSY(busy5), .OUT_STROBE(strb5)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; t[i] = 0; d[i] = 0; age[i] = 0;
        end
    endtask

    task automatic model_clock();
        for (int i = 0; i < 2; i++) begin
            if (abort) begin
                mode[i] = 0;
            end else if (mode[i] == 0) begin
                if (start) begin
                    mode[i] = 1; t[i] = 0; d[i] = int'(dwell);
                end
            end else if (mode[i] == 1) begin
                t[i]++;
                if (t[i] == (nst[i] - 1) * (d[i] + 1)) begin
                    mode[i] = 2; age[i] = 0;
                end
            end else begin
                age[i]++;
                if (clr) mode[i] = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_en(input int i);
        int k;
        if (mode[i] == 0) return 32'd1;
        if (mode[i] == 2) return 32'd0;
        k = 1 + t[i] / (d[i] + 1);
        return 32'((1 << (k + 1)) - 1);
    endfunction

    function automatic logic [31:0] exp_strb(input int i);
        if (mode[i] != 2) return 32'd0;
`ifdef SEQ_STROBE_PULSE_EN
        return (age[i] == 0) ? 32'd1 : 32'd0;
`else
        return 32'd1;
`endif
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".en3"},   32'(en3),   exp_en(0));
        check_eq({tag, ".busy3"}, 32'(busy3), (mode[0] == 1) ? 32'd1 : 32'd0);
        check_eq({tag, ".strb3"}, 32'(strb3), exp_strb(0));
        check_eq({tag, ".en5"},   32'(en5),   exp_en(1));
        check_eq({tag, ".busy5"}, 32'(busy5), (mode[1] == 1) ? 32'd1 : 32'd0);
        check_eq({tag, ".strb5"}, 32'(strb5), exp_strb(1));
    endtask

    // One clock: DUT and model advance on the same edge, outputs checked #1 later.
    task automatic step(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_clock();
            #1;
            check_all(tag);
        end
    endtask

    task automatic pulse_start(input string tag, input int dw);
        dwell = DW'(dw);
        start = 1'b1;
        step(tag, 1);
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        #2 rst = 1'b1;
        #1 check_all("reset");
        #4 rst = 1'b0;
        step("idle", 2);

        // Legacy timing with zero dwell, then hold STOP.
        pulse_start("legacy", 0);
        step("legacy", 6);
        clr = 1'b1; step("clr", 1); clr = 1'b0;

        // Dwell 1; DWELL changed mid-ramp must not alter timing.
        pulse_start("dwell1", 1);
        step("dwell1", 2);
        dwell = DW'(7);
        step("dwell1_chg", 8);
        clr = 1'b1; step("clr2", 1); clr = 1'b0;

        // Abort in 2nd cycle of EN=111 for N=3 at dwell 3.
        pulse_start("abort_run", 3);
        step("abort_run", 5);
        check_eq("abort_pre.en3", 32'(en3), 32'd7);
        abort = 1'b1; step("abort", 1); abort = 1'b0;
        step("abort_post", 1);

        // START together with ABORT in IDLE stays idle.
        start = 1'b1; abort = 1'b1; step("start_abort", 1);
        start = 1'b0; abort = 1'b0; step("start_abort_post", 1);

        // Re-arm: START ignored in STOP, then CLR, then dwell 2.
        pulse_start("rearm", 0);
        step("rearm", 4);
        start = 1'b1; step("stop_start", 5); start = 1'b0;
        clr = 1'b1; step("rearm_clr", 1); clr = 1'b0;
        pulse_start("dwell2", 2);
        step("dwell2", 14);
        clr = 1'b1; step("clr3", 1); clr = 1'b0;

        // Asynchronous reset mid-ramp, observed before the next edge.
        pulse_start("arst_run", 0);
        step("arst_run", 1);
        check_eq("arst_pre.en3", 32'(en3), 32'd7);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("arst");
        #1 rst = 1'b0;
        step("arst_post", 1);

        // Randomised stimulus.
        for (int r = 0; r < 400; r++) begin
            start = ($urandom_range(0, 2) == 0);
            abort = ($urandom_range(0, 15) == 0);
            clr   = ($urandom_range(0, 3) == 0);
            dwell = DW'($urandom_range(0, 3));
            step("rand", 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
